// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared types for the multi-cycle sequencer of the 9-bit-ISA
//            datapath: opcode map, ALU operation codes, FSM states and the
//            opcode-to-ALU-operation mapping.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Opcode field, taken from IR[4:1]
    typedef enum logic [3:0] {
        OPC_LDI     = 4'd0,
        OPC_LD      = 4'd1,
        OPC_ST      = 4'd2,
        OPC_ADD     = 4'd3,
        OPC_SUB     = 4'd4,
        OPC_XOR     = 4'd5,
        OPC_OR      = 4'd6,
        OPC_AND     = 4'd7,
        OPC_JMP     = 4'd8,
        OPC_BEQ     = 4'd9,
        OPC_BLT     = 4'd10,
        OPC_BGT     = 4'd11,
        OPC_LS      = 4'd12,
        OPC_RS      = 4'd13,
        OPC_ILLEGAL = 4'd14,
        OPC_HALT    = 4'd15
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_XOR  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_LS   = 4'b0011,
        ALU_RS   = 4'b0100,
        ALU_ADD  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_PASS = 4'b0111,
        ALU_BLT  = 4'b1000,
        ALU_BGT  = 4'b1001,
        ALU_BEQ  = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    // ALU operation issued for each opcode; halt/illegal never execute,
    // so they fall back to the all-zero code.
    function automatic alu_op_e alu_op_for(input opcode_e op);
        case (op)
            OPC_LDI, OPC_LD, OPC_ST, OPC_JMP: return ALU_PASS;
            OPC_ADD: return ALU_ADD;
            OPC_SUB: return ALU_SUB;
            OPC_XOR: return ALU_XOR;
            OPC_OR:  return ALU_OR;
            OPC_AND: return ALU_AND;
            OPC_BEQ: return ALU_BEQ;
            OPC_BLT: return ALU_BLT;
            OPC_BGT: return ALU_BGT;
            OPC_LS:  return ALU_LS;
            OPC_RS:  return ALU_RS;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_wait_timer
// Purpose  : Counts non-ready cycles while the sequencer waits on a memory
//            handshake and flags expiry on the cycle that would make the
//            count reach MEM_TIMEOUT.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            i_active      - sequencer is in a memory wait state
//            i_ready       - handshake ready for the current wait
//            o_expired     - this non-ready cycle is the last one allowed
// Revision : 1.0 - initial release
// ============================================================================
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);

    localparam logic [7:0] c_LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Every exit from a wait state happens on a ready cycle or goes to a
    // non-wait state, so clearing on ready/inactive gives a zero count on
    // every entry, including the direct MEM -> FETCH path of a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || i_ready) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Wait cycles are numbered from 0; ready on cycle MEM_TIMEOUT-1 is
    // still accepted because ready has priority over expiry.
    assign o_expired = i_active && !i_ready && (r_cnt == c_LAST_WAIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Multi-cycle control FSM for the 9-bit-ISA datapath
//            (FETCH, DECODE, EXEC, MEM, WB) with guarded memory waits.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            start                 - run request, honoured in IDLE/HALT only
//            instruction           - imem word, opcode in [4:1]
//            imem_ready/dmem_ready - memory handshakes
//            alu_cond              - branch compare result
//            imem_req, dmem_req, dmem_we, reg_we, mem_to_reg, imm_to_reg,
//            pc_clr, pc_inc, pc_load, alu_op - datapath controls
//            busy, done, err       - status
//            cycle_cnt, instr_cnt  - performance counters
// Config   : SEQ_PERF_CNT_EN - when defined, cycle_cnt/instr_cnt are live
//            saturating counters; otherwise both read 0.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [8:0]       instruction,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             alu_cond,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             imm_to_reg,
    output logic             pc_clr,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [3:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    import seq_pkg::*;

    state_e  r_state;
    logic [8:0] r_ir;
    alu_op_e r_alu_op;

    opcode_e w_opc;
    logic    w_is_branch;
    logic    w_start_acc;
    logic    w_wait_active;
    logic    w_wait_ready;
    logic    w_expired;
    logic    w_unused_ir;

    assign w_opc       = opcode_e'(r_ir[4:1]);
    assign w_is_branch = (w_opc == OPC_BEQ) || (w_opc == OPC_BLT) || (w_opc == OPC_BGT);
    // Gated by rst_n so pc_clr stays low while reset is held.
    assign w_start_acc = rst_n && start && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_wait_active = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_wait_ready  = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    // Only the opcode field steers control; the operand bits go to the datapath.
    assign w_unused_ir = ^{r_ir[8:5], r_ir[0]};
    assign alu_op      = r_alu_op;

    seq_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_wait_active),
        .i_ready   (w_wait_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ir     <= '0;
            r_alu_op <= ALU_AND;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= instruction;
                        r_state <= S_DECODE;
                    end else if (w_expired) begin
                        r_state <= S_ERR;
                    end
                end
                S_DECODE: begin
                    r_alu_op <= alu_op_for(w_opc);
                    if (w_opc == OPC_HALT)         r_state <= S_HALT;
                    else if (w_opc == OPC_ILLEGAL) r_state <= S_ERR;
                    else                           r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if ((w_opc == OPC_LD) || (w_opc == OPC_ST)) r_state <= S_MEM;
                    else if ((w_opc == OPC_JMP) || w_is_branch) r_state <= S_FETCH;
                    else                                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_opc == OPC_LD) r_state <= S_WB;
                        else                 r_state <= S_FETCH;
                    end else if (w_expired) begin
                        r_state <= S_ERR;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    if (w_start_acc) r_state <= S_FETCH;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-phase strobes decoded from the current state (and, for the
    // branch and store-completion cycles, from the qualifying input).
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        imm_to_reg = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_clr     = w_start_acc;
        busy       = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);
        done       = (r_state == S_HALT) || (r_state == S_ERR);
        err        = (r_state == S_ERR);
        case (r_state)
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
                if (w_opc == OPC_JMP) begin
                    pc_load = 1'b1;
                end else if (w_is_branch) begin
                    pc_load = alu_cond;
                    pc_inc  = !alu_cond;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_opc == OPC_ST);
                // A store retires on its completion cycle; a load retires in WB.
                pc_inc   = (w_opc == OPC_ST) && dmem_ready;
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_inc     = 1'b1;
                mem_to_reg = (w_opc == OPC_LD);
                imm_to_reg = (w_opc == OPC_LDI);
            end
            default: ;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (w_start_acc) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (busy && !(&r_cycle_cnt))
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if ((pc_inc || pc_load) && !(&r_instr_cnt))
                r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the 9-bit-ISA datapath: fetch, decode, execute, memory and writeback.
- Drives per-phase strobes: IR load, PC update, memory request/write, register write, ALU op.
- Waits on instruction- and data-memory ready handshakes and guards each wait with a timeout.
- Sits between the top-level start/done interface and the register file, ALU, PC and memories.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for imem_ready or dmem_ready before entering ERR; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or HALT
- instruction  in  9  instruction word from imem; opcode is instruction[4:1]
- imem_ready  in  1  instruction word valid
- dmem_ready  in  1  data access complete
- alu_cond  in  1  ALU compare result, used by beq/blt/bgt
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write (store)
- reg_we  out  1  register file write enable
- mem_to_reg  out  1  writeback source is memory
- imm_to_reg  out  1  writeback source is immediate
- pc_clr  out  1  PC clear pulse
- pc_inc  out  1  PC+1 pulse
- pc_load  out  1  branch target load pulse
- alu_op  out  4  ALU operation
- busy  out  1  high in any state other than IDLE, HALT or ERR
- done  out  1  program finished
- err  out  1  timeout or illegal opcode
- cycle_cnt  out  CNT_W  feature-gated counter
- instr_cnt  out  CNT_W  feature-gated counter

Behaviour:
- Reset (asynchronous, any time, including mid-access):
  - state goes to IDLE; IR cleared; every output driven 0.
  - In-flight memory requests are dropped without completion.
- Opcode decode from IR[4:1]:
  - 0 ldi, 1 ld, 2 st, 3 add, 4 sub, 5 xor, 6 or, 7 and
  - 8 jmp, 9 beq, 10 blt, 11 bgt, 12 ls, 13 rs
  - 14 illegal, 15 halt
- ALU op encoding:
  - and 0000, xor 0001, or 0010, ls 0011, rs 0100, add 0101, sub 0110
  - ldi/ld/st/jmp use pass 0111; blt 1000; bgt 1001; beq 1010
  - alu_op is registered at DECODE exit, held until the next DECODE, and is 0000 in IDLE.
- IDLE:
  - start -> FETCH, with pc_clr=1 for one cycle.
- FETCH:
  - imem_req=1 held until imem_ready.
  - On the imem_ready cycle, IR <= instruction and next state is DECODE.
  - The wait counter increments each non-ready cycle; reaching MEM_TIMEOUT -> ERR.
- DECODE (1 cycle):
  - opcode 15 -> HALT.
  - opcode 14 -> ERR.
  - otherwise -> EXEC.
- EXEC (1 cycle):
  - ld/st -> MEM.
  - jmp: pc_load=1 -> FETCH.
  - beq/blt/bgt: pc_load=alu_cond and pc_inc=!alu_cond -> FETCH.
  - all other opcodes -> WB.
- MEM:
  - dmem_req=1; dmem_we=1 only for st.
  - Hold both until dmem_ready, with the same timeout rule as FETCH.
  - ld -> WB.
  - st: pc_inc=1 on the ready cycle -> FETCH.
- WB (1 cycle):
  - reg_we=1, pc_inc=1.
  - mem_to_reg=1 for ld; imm_to_reg=1 for ldi.
  - -> FETCH.
- HALT:
  - done=1 held.
  - start -> FETCH with pc_clr, and done drops the next cycle.
- ERR:
  - err=1 and done=1 held; start is ignored; exit only via reset.
- Strobes are combinational from state; exactly one of pc_inc or pc_load fires per retired non-halt instruction.
- Latency with zero-wait memories:
  - ALU ops and ldi: 4 cycles
  - ld: 5 cycles
  - st: 4 cycles
  - branch/jump: 3 cycles
- Timeout boundary:
  - Ready arriving on wait cycle MEM_TIMEOUT-1 is accepted.
  - Ready arriving on cycle MEM_TIMEOUT is not.
- start outside IDLE/HALT is ignored.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle while busy.
  - instr_cnt increments on each pc_inc or pc_load.
  - Both clear on reset and on accepted start; both saturate at all-ones.
- Undefined:
  - Both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package seq_pkg:
  - opcode_e (4-bit)
  - alu_op_e (4-bit)
  - state_e (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR)
  - OPC_ILLEGAL=14, OPC_HALT=15
- Sub-module seq_wait_timer: clears on state entry, counts non-ready cycles, flags expiry at MEM_TIMEOUT.

Test Plan:
- Reset, then start, imem returns 9'b000000110 (add) with zero wait -> states FETCH, DECODE, EXEC, WB; reg_we=1 and pc_inc=1 in cycle 4; alu_op=0101.
- ld (9'b000000010) with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with mem_to_reg=1; 8 cycles total.
- beq (9'b000010010) with alu_cond=1, then again with alu_cond=0 -> first gives pc_load=1, pc_inc=0, alu_op=1010, reg_we=0; second gives pc_inc=1.
- imem_ready never asserted, MEM_TIMEOUT=16 -> err=1 and done=1 after 16 FETCH cycles; a subsequent start is ignored.
- halt opcode (9'b000011110) -> done=1 held; start then gives pc_clr pulse and done=0 next cycle; illegal opcode 14 -> err=1.
- rst_n dropped mid-MEM during st -> dmem_req and dmem_we go 0 immediately; state IDLE; with SEQ_PERF_CNT_EN defined, both counters read 0.
